// File: rtl/dc_load_align.sv
// dc_load_align
//   Load-return stage behind the L1 data-cache databank array. Per-load metadata
//   (id, size, signedness, byte offset) is queued in request order and paired with
//   the next 36-bit databank response. The addressed byte/half/word is extracted,
//   zero- or sign-extended to 64 bits, and flagged as misaligned or missing.
//   The result is held in a one-entry registered output with valid/retry handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   meta_*              load metadata push (meta_retry = FIFO full)
//   bank_ack_*          databank response (data[31:0], byte-valid[35:32])
//   ld_ack_*            extended result to the load unit
module dc_load_align #(
    parameter int unsigned META_DEPTH = 4,
    parameter int unsigned ID_BITS    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               meta_valid,
    output logic               meta_retry,
    input  logic [ID_BITS-1:0] meta_id,
    input  logic [1:0]         meta_size,
    input  logic               meta_signed,
    input  logic [1:0]         meta_off,
    input  logic               bank_ack_valid,
    output logic               bank_ack_retry,
    input  logic [35:0]        bank_ack_data,
    output logic               ld_ack_valid,
    input  logic               ld_ack_retry,
    output logic [ID_BITS-1:0] ld_ack_id,
    output logic [63:0]        ld_ack_data,
    output logic               ld_ack_miss,
    output logic               ld_ack_misalign
);

    localparam int unsigned PtrW  = $clog2(META_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned MetaW = ID_BITS + 5;

    localparam logic [CntW-1:0] CntFull = CntW'(META_DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    // ---------------- metadata FIFO ----------------
    logic [MetaW-1:0] meta_mem_q [META_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    logic push, pop;

    // Full is judged on the registered count only; a same-cycle pop frees nothing.
    assign meta_retry     = (count_q == CntFull);
    assign bank_ack_retry = (count_q == '0) || (ld_ack_valid && ld_ack_retry);
    assign push           = meta_valid && !meta_retry;
    assign pop            = bank_ack_valid && !bank_ack_retry;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            meta_mem_q[wr_ptr_q] <= {meta_id, meta_size, meta_signed, meta_off};
        end
    end

    // ---------------- alignment / extension ----------------
    logic [ID_BITS-1:0] h_id;
    logic [1:0]         h_size;
    logic               h_sgn;
    logic [1:0]         h_off;
    logic [31:0]        shifted;
    logic [3:0]         req_mask;
    logic               res_misalign;
    logic               res_miss;
    logic [63:0]        ext;
    logic [63:0]        res_data;

    always_comb begin
        {h_id, h_size, h_sgn, h_off} = meta_mem_q[rd_ptr_q];

        // Move the addressed byte lane down to bit 0.
        shifted = bank_ack_data[31:0] >> {h_off, 3'b000};

        case (h_size)
            2'd0:    req_mask = 4'b0001 << h_off;
            2'd1:    req_mask = 4'b0011 << h_off;
            default: req_mask = 4'b1111;
        endcase

        res_misalign = (h_size == 2'd3) ||
                       (h_size == 2'd1 && h_off[0]) ||
                       (h_size == 2'd2 && h_off != 2'd0);
        res_miss     = !res_misalign && |(req_mask & ~bank_ack_data[35:32]);

        case (h_size)
            2'd0:    ext = {{56{h_sgn & shifted[7]}},  shifted[7:0]};
            2'd1:    ext = {{48{h_sgn & shifted[15]}}, shifted[15:0]};
            2'd2:    ext = {{32{h_sgn & shifted[31]}}, shifted[31:0]};
            default: ext = '0;
        endcase

        res_data = (res_misalign || res_miss) ? 64'd0 : ext;
    end

    // ---------------- output register ----------------
    logic               out_valid_q, out_valid_d;
    logic [ID_BITS-1:0] out_id_q;
    logic [63:0]        out_data_q;
    logic               out_miss_q;
    logic               out_misalign_q;

    always_comb begin
        out_valid_d = out_valid_q;
        if (pop) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && !ld_ack_retry) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            out_data_q     <= '0;
            out_miss_q     <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (pop) begin
                out_id_q       <= h_id;
                out_data_q     <= res_data;
                out_miss_q     <= res_miss;
                out_misalign_q <= res_misalign;
            end
        end
    end

    assign ld_ack_valid    = out_valid_q;
    assign ld_ack_id       = out_id_q;
    assign ld_ack_data     = out_data_q;
    assign ld_ack_miss     = out_miss_q;
    assign ld_ack_misalign = out_misalign_q;

endmodule
